// File: rtl/cylon_scanner_if.sv
// Tick-generator side inputs and LED-bar side outputs of the cylon scanner.
// The master drives step/enable and the slave (the scanner) drives the bar.
interface cylon_scanner_if #(
    parameter int NUM_LEDS = 8
);
    localparam int PW = $clog2(NUM_LEDS);

    logic                step_pulse;
    logic                enable;
    logic [NUM_LEDS-1:0] leds;
    logic [PW-1:0]       position;
    logic                dir;
    logic                bounce;

    modport master (
        output step_pulse, enable,
        input  leds, position, dir, bounce
    );

    modport slave (
        input  step_pulse, enable,
        output leds, position, dir, bounce
    );
endinterface

// File: rtl/cylon_scanner.sv
// Bouncing "cylon" eye on an LED bar: a head steps once per tick, dwells at
// each end, and leaves a halving-brightness trail rendered by a free-running PWM.
module cylon_scanner #(
    parameter int NUM_LEDS    = 8,
    parameter int PWM_BITS    = 4,
    parameter int DWELL_STEPS = 2
) (
    input  logic            clk,
    input  logic            rst,
    cylon_scanner_if.slave  bus
);
    localparam int PW  = $clog2(NUM_LEDS);
    localparam int DCW = $clog2(DWELL_STEPS + 2);
    localparam logic [PW-1:0]       LAST_POS   = PW'(NUM_LEDS - 1);
    localparam logic [PWM_BITS-1:0] MAX_BRIGHT = '1;
    // The pulse that enters DWELL counts as the first held tick, so the
    // reversal fires once dwell_cnt has reached DWELL_STEPS-2.
    localparam logic [DCW-1:0]      DWELL_LAST = DCW'((DWELL_STEPS > 1) ? (DWELL_STEPS - 2) : 0);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DWELL
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       position_q, position_d;
    logic                dir_q, dir_d;
    logic                bounce_q, bounce_d;
    logic [DCW-1:0]      dwell_cnt_q, dwell_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] bright_q [NUM_LEDS];
    logic [PWM_BITS-1:0] bright_d [NUM_LEDS];
    logic [NUM_LEDS-1:0] leds_q, leds_d;

    logic          at_end;
    logic [PW-1:0] fwd_pos;
    logic [PW-1:0] back_pos;

    assign pwm_cnt_d = pwm_cnt_q + 1'b1;

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
        assign leds_d[gi] = (pwm_cnt_q < bright_q[gi]);
    end

    always_comb begin
        state_d     = state_q;
        position_d  = position_q;
        dir_d       = dir_q;
        bounce_d    = 1'b0;
        dwell_cnt_d = dwell_cnt_q;
        bright_d    = bright_q;
        at_end      = dir_q ? (position_q == LAST_POS) : (position_q == '0);
        fwd_pos     = dir_q ? (position_q + 1'b1) : (position_q - 1'b1);
        back_pos    = dir_q ? (position_q - 1'b1) : (position_q + 1'b1);

        case (state_q)
            IDLE: begin
                position_d  = '0;
                dir_d       = 1'b1;
                dwell_cnt_d = '0;
                for (int i = 0; i < NUM_LEDS; i++) bright_d[i] = '0;
                if (bus.enable) begin
                    state_d     = RUN;
                    bright_d[0] = MAX_BRIGHT;
                end
            end
            RUN, DWELL: begin
                if (!bus.enable) begin
                    state_d     = IDLE;
                    position_d  = '0;
                    dir_d       = 1'b1;
                    dwell_cnt_d = '0;
                    for (int i = 0; i < NUM_LEDS; i++) bright_d[i] = '0;
                end else if (bus.step_pulse) begin
                    for (int i = 0; i < NUM_LEDS; i++) bright_d[i] = bright_q[i] >> 1;
                    if (state_q == RUN && !at_end) begin
                        position_d = fwd_pos;
                    end else if (state_q == RUN && DWELL_STEPS != 0) begin
                        state_d     = DWELL;
                        dwell_cnt_d = '0;
                    end else if (state_q == DWELL && dwell_cnt_q != DWELL_LAST) begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end else begin
                        state_d     = RUN;
                        dir_d       = !dir_q;
                        bounce_d    = 1'b1;
                        position_d  = back_pos;
                        dwell_cnt_d = '0;
                    end
                    // Whoever is head after this step is always at full brightness.
                    bright_d[position_d] = MAX_BRIGHT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            position_q  <= '0;
            dir_q       <= 1'b1;
            bounce_q    <= 1'b0;
            dwell_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            leds_q      <= '0;
            for (int i = 0; i < NUM_LEDS; i++) bright_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            position_q  <= position_d;
            dir_q       <= dir_d;
            bounce_q    <= bounce_d;
            dwell_cnt_q <= dwell_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            leds_q      <= leds_d;
            for (int i = 0; i < NUM_LEDS; i++) bright_q[i] <= bright_d[i];
        end
    end

    assign bus.leds     = leds_q;
    assign bus.position = position_q;
    assign bus.dir      = dir_q;
    assign bus.bounce   = bounce_q;
endmodule

// File: tb/tb_cylon_scanner.sv
// Directed bench for the cylon scanner: dut_a uses a 2-tick end dwell,
// dut_b reverses immediately and is driven with back-to-back ticks.
module tb_cylon_scanner;
    localparam int NUM_LEDS = 8;
    localparam logic [2:0] B2B_POS [20] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                                            3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0,
                                            3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    localparam logic [19:0] B2B_DIR    = 20'hFC07F;
    localparam logic [19:0] B2B_BOUNCE = 20'h04080;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors = 0;
    int   bounce_cnt_a = 0;
    int   duty [NUM_LEDS];

    cylon_scanner_if #(.NUM_LEDS(NUM_LEDS)) ifa ();
    cylon_scanner_if #(.NUM_LEDS(NUM_LEDS)) ifb ();

    cylon_scanner #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(4), .DWELL_STEPS(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    cylon_scanner #(.NUM_LEDS(NUM_LEDS), .PWM_BITS(4), .DWELL_STEPS(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ifa.bounce === 1'b1) bounce_cnt_a++;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input int gap);
        ifa.step_pulse = 1'b1;
        cyc();
        ifa.step_pulse = 1'b0;
        $display("tick a: position=%0d dir=%0d bounce=%0d", ifa.position, ifa.dir, ifa.bounce);
        repeat (gap) cyc();
    endtask

    task automatic measure_duty();
        for (int i = 0; i < NUM_LEDS; i++) duty[i] = 0;
        cyc();
        cyc();
        for (int c = 0; c < 16; c++) begin
            cyc();
            for (int i = 0; i < NUM_LEDS; i++) if (ifa.leds[i] === 1'b1) duty[i]++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            ifa.step_pulse = c[0];
            cyc();
            vectors++;
            if (ifa.leds !== 8'h00 || ifa.position !== 3'd0 || ifa.dir !== 1'b1 || ifa.bounce !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: leds=%h pos=%0d dir=%b bounce=%b, expected leds=00 pos=0 dir=1 bounce=0",
                         ifa.leds, ifa.position, ifa.dir, ifa.bounce);
            end
        end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            ifa.step_pulse = c[0];
            ifb.step_pulse = c[0];
            cyc();
            vectors++;
            if (ifa.leds !== 8'h00 || ifa.position !== 3'd0 || ifa.dir !== 1'b1 || ifa.bounce !== 1'b0 ||
                ifb.leds !== 8'h00 || ifb.position !== 3'd0) begin
                errors++;
                $display("FAIL idle_state: a leds=%h pos=%0d dir=%b bounce=%b b leds=%h pos=%0d, expected 00/0/1/0 00/0",
                         ifa.leds, ifa.position, ifa.dir, ifa.bounce, ifb.leds, ifb.position);
            end
        end
        ifa.step_pulse = 1'b0;
        ifb.step_pulse = 1'b0;
        vectors++;
        if (bounce_cnt_a != 0) begin
            errors++;
            $display("FAIL idle_bounce: got %0d bounce pulses, expected 0", bounce_cnt_a);
        end
    endtask

    task automatic test_sweep_up();
        int exp_d [NUM_LEDS] = '{1, 3, 7, 15, 0, 0, 0, 0};
        ifa.enable = 1'b1;
        cyc();
        vectors++;
        if (ifa.position !== 3'd0 || ifa.dir !== 1'b1) begin
            errors++;
            $display("FAIL sweep_start: pos=%0d dir=%b, expected pos=0 dir=1", ifa.position, ifa.dir);
        end
        repeat (3) cyc();
        for (int k = 1; k <= 7; k++) begin
            pulse_a(9);
            vectors++;
            if (ifa.position !== 3'(k) || ifa.dir !== 1'b1) begin
                errors++;
                $display("FAIL sweep_pos: pulse %0d pos=%0d dir=%b, expected pos=%0d dir=1", k, ifa.position, ifa.dir, k);
            end
            if (k == 3) begin
                measure_duty();
                for (int i = 0; i < NUM_LEDS; i++) begin
                    vectors++;
                    if (duty[i] != exp_d[i]) begin
                        errors++;
                        $display("FAIL sweep_duty: led %0d lit %0d of 16, expected %0d", i, duty[i], exp_d[i]);
                    end
                end
            end
        end
        vectors++;
        if (bounce_cnt_a != 0) begin
            errors++;
            $display("FAIL sweep_bounce: got %0d bounce pulses, expected 0", bounce_cnt_a);
        end
    endtask

    task automatic test_dwell_reversal();
        int exp_d [NUM_LEDS] = '{0, 0, 0, 0, 0, 0, 15, 7};
        pulse_a(0);
        vectors++;
        if (ifa.position !== 3'd7 || ifa.dir !== 1'b1 || ifa.bounce !== 1'b0) begin
            errors++;
            $display("FAIL dwell_hold: pos=%0d dir=%b bounce=%b, expected pos=7 dir=1 bounce=0", ifa.position, ifa.dir, ifa.bounce);
        end
        repeat (9) cyc();
        pulse_a(0);
        vectors++;
        if (ifa.position !== 3'd6 || ifa.dir !== 1'b0 || ifa.bounce !== 1'b1) begin
            errors++;
            $display("FAIL top_reverse: pos=%0d dir=%b bounce=%b, expected pos=6 dir=0 bounce=1", ifa.position, ifa.dir, ifa.bounce);
        end
        cyc();
        vectors++;
        if (ifa.bounce !== 1'b0) begin
            errors++;
            $display("FAIL top_bounce_width: bounce=%b one clk later, expected 0", ifa.bounce);
        end
        measure_duty();
        for (int i = 0; i < NUM_LEDS; i++) begin
            vectors++;
            if (duty[i] != exp_d[i]) begin
                errors++;
                $display("FAIL reverse_duty: led %0d lit %0d of 16, expected %0d", i, duty[i], exp_d[i]);
            end
        end
        pulse_a(3);
        vectors++;
        if (ifa.position !== 3'd5 || ifa.dir !== 1'b0) begin
            errors++;
            $display("FAIL after_reverse: pos=%0d dir=%b, expected pos=5 dir=0", ifa.position, ifa.dir);
        end
    endtask

    task automatic test_lower_end();
        int b0;
        for (int n = 0; n < 10 && ifa.position !== 3'd0; n++) pulse_a(2);
        vectors++;
        if (ifa.position !== 3'd0 || ifa.dir !== 1'b0) begin
            errors++;
            $display("FAIL reach_bottom: pos=%0d dir=%b, expected pos=0 dir=0", ifa.position, ifa.dir);
        end
        pulse_a(0);
        vectors++;
        if (ifa.position !== 3'd0 || ifa.dir !== 1'b0 || ifa.bounce !== 1'b0) begin
            errors++;
            $display("FAIL bottom_hold: pos=%0d dir=%b bounce=%b, expected pos=0 dir=0 bounce=0", ifa.position, ifa.dir, ifa.bounce);
        end
        cyc();
        pulse_a(0);
        vectors++;
        if (ifa.position !== 3'd1 || ifa.dir !== 1'b1 || ifa.bounce !== 1'b1) begin
            errors++;
            $display("FAIL bottom_reverse: pos=%0d dir=%b bounce=%b, expected pos=1 dir=1 bounce=1", ifa.position, ifa.dir, ifa.bounce);
        end
        cyc();
        vectors++;
        if (ifa.bounce !== 1'b0 || bounce_cnt_a != 2) begin
            errors++;
            $display("FAIL first_trip_bounces: bounce=%b count=%0d, expected bounce=0 count=2", ifa.bounce, bounce_cnt_a);
        end
        b0 = bounce_cnt_a;
        repeat (16) pulse_a(1);
        vectors++;
        if (bounce_cnt_a - b0 != 2 || ifa.position !== 3'd1 || ifa.dir !== 1'b1) begin
            errors++;
            $display("FAIL round_trip: bounces=%0d pos=%0d dir=%b, expected bounces=2 pos=1 dir=1",
                     bounce_cnt_a - b0, ifa.position, ifa.dir);
        end
    endtask

    task automatic test_disable();
        int exp_d [NUM_LEDS] = '{15, 0, 0, 0, 0, 0, 0, 0};
        repeat (3) pulse_a(2);
        vectors++;
        if (ifa.position !== 3'd4) begin
            errors++;
            $display("FAIL pre_disable: pos=%0d, expected 4", ifa.position);
        end
        ifa.enable     = 1'b0;
        ifa.step_pulse = 1'b1;
        cyc();
        ifa.step_pulse = 1'b0;
        vectors++;
        if (ifa.position !== 3'd0 || ifa.dir !== 1'b1 || ifa.bounce !== 1'b0) begin
            errors++;
            $display("FAIL disable_park: pos=%0d dir=%b bounce=%b, expected pos=0 dir=1 bounce=0", ifa.position, ifa.dir, ifa.bounce);
        end
        cyc();
        vectors++;
        if (ifa.leds !== 8'h00) begin
            errors++;
            $display("FAIL disable_blank: leds=%h, expected 00", ifa.leds);
        end
        pulse_a(16);
        vectors++;
        if (ifa.position !== 3'd0 || ifa.leds !== 8'h00) begin
            errors++;
            $display("FAIL idle_ignores_step: pos=%0d leds=%h, expected pos=0 leds=00", ifa.position, ifa.leds);
        end
        ifa.enable = 1'b1;
        cyc();
        measure_duty();
        for (int i = 0; i < NUM_LEDS; i++) begin
            vectors++;
            if (duty[i] != exp_d[i]) begin
                errors++;
                $display("FAIL reenable_duty: led %0d lit %0d of 16, expected %0d", i, duty[i], exp_d[i]);
            end
        end
        pulse_a(0);
        vectors++;
        if (ifa.position !== 3'd1 || ifa.dir !== 1'b1) begin
            errors++;
            $display("FAIL reenable_step: pos=%0d dir=%b, expected pos=1 dir=1", ifa.position, ifa.dir);
        end
    endtask

    task automatic test_back_to_back();
        ifb.enable = 1'b1;
        cyc();
        vectors++;
        if (ifb.position !== 3'd0 || ifb.dir !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start: pos=%0d dir=%b, expected pos=0 dir=1", ifb.position, ifb.dir);
        end
        ifb.step_pulse = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            $display("tick b: step %0d position=%0d dir=%0d bounce=%0d", k + 1, ifb.position, ifb.dir, ifb.bounce);
            vectors++;
            if (ifb.position !== B2B_POS[k] || ifb.dir !== B2B_DIR[k] || ifb.bounce !== B2B_BOUNCE[k]) begin
                errors++;
                $display("FAIL b2b_step %0d: pos=%0d dir=%b bounce=%b, expected pos=%0d dir=%b bounce=%b",
                         k + 1, ifb.position, ifb.dir, ifb.bounce, B2B_POS[k], B2B_DIR[k], B2B_BOUNCE[k]);
            end
        end
        ifb.step_pulse = 1'b0;
        ifb.enable     = 1'b0;
        cyc();
    endtask

    initial begin
        ifa.step_pulse = 1'b0;
        ifa.enable     = 1'b0;
        ifb.step_pulse = 1'b0;
        ifb.enable     = 1'b0;
        test_reset();
        test_sweep_up();
        test_dwell_reversal();
        test_lower_end();
        test_disable();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
